// File: rtl/sequence_player.sv
// sequence_player: plays back a stored colour sequence on a one-hot LED display.
//
// On start, entries 0..min(level, DEPTH)-1 are read from an external registered
// ROM (sequence_rom) one at a time. Each entry is fetched (FETCH), latched
// (LATCH), shown for ON_CYCLES cycles (SHOW) and followed by an OFF_CYCLES dark
// gap (GAP). After the last entry a one-cycle done pulse is issued (FIN).
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous, active-high reset
//   start    in   one-cycle playback request (ignored unless idle)
//   abort    in   stop playback at the next edge, no done pulse
//   level    in   number of entries to play (clamped to DEPTH)
//   rd_addr  out  read address to sequence_rom
//   rd_data  in   registered read data from sequence_rom (colour code)
//   led      out  one-hot colour display, bit n lit for colour n
//   busy     out  high while playback is in progress
//   done     out  one-cycle pulse when playback completes normally
module sequence_player #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] level,
  output logic [3:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic [3:0] led,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] OnLast  = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] OffLast = CntW'(OFF_CYCLES - 1);
  // Five bits so that DEPTH = 16 is representable.
  localparam logic [4:0]      DepthW  = 5'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StShow,
    StGap,
    StFin
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      eff_q, eff_d;
  logic [1:0]      colour_q, colour_d;
  logic [3:0]      rd_addr_q, rd_addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [4:0] eff_load;
  logic [4:0] idx_inc;

  // Effective level is min(level, DEPTH); only sampled on leaving IDLE.
  assign eff_load = ({1'b0, level} > DepthW) ? DepthW : {1'b0, level};
  assign idx_inc  = {1'b0, idx_q} + 5'd1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      eff_q     <= 5'd0;
      colour_q  <= 2'd0;
      rd_addr_q <= 4'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      eff_q     <= eff_d;
      colour_q  <= colour_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = (eff_load == 5'd0) ? StFin : StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: state_d = StShow;
      StShow: begin
        if (cnt_q == OnLast) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == OffLast) begin
          state_d = (idx_inc < eff_q) ? StFetch : StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides every other transition out of a non-idle state.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Datapath next-state: index, level, colour, address and phase counter.
  always_comb begin
    idx_d     = idx_q;
    eff_d     = eff_q;
    colour_d  = colour_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = '0;

    // Counter only runs while staying in SHOW or GAP; any state change clears it.
    if ((state_d == state_q) && ((state_q == StShow) || (state_q == StGap))) begin
      cnt_d = cnt_q + CntW'(1);
    end

    if ((state_q == StIdle) && (state_d != StIdle)) begin
      idx_d = 4'd0;
      eff_d = eff_load;
    end

    if ((state_q == StGap) && (state_d == StFetch)) begin
      idx_d = idx_inc[3:0];
    end

    // Address is registered on entry to FETCH and held through LATCH and beyond,
    // so the ROM sees it at the FETCH->LATCH edge and its output is valid at the
    // LATCH->SHOW edge.
    if (state_d == StFetch) begin
      rd_addr_d = idx_d;
    end

    if ((state_q == StLatch) && (state_d == StShow)) begin
      colour_d = rd_data;
    end
  end

  // Outputs.
  always_comb begin
    led  = 4'b0000;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StFetch, StLatch, StGap: busy = 1'b1;
      StShow: begin
        busy = 1'b1;
        led  = 4'b0001 << colour_q;
      end
      StFin:   done = 1'b1;
      default: ;
    endcase
  end

  assign rd_addr = rd_addr_q;

  // Display must never show two colours at once.
  led_onehot_a: assert property (@(posedge clk) $onehot0(led));
  // Address never leaves the populated ROM range.
  rd_addr_range_a: assert property (@(posedge clk) ({1'b0, rd_addr} < DepthW));

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter DEPTH, 16, number of stored sequence entries; addresses are 0..DEPTH-1 and DEPTH SHALL be no greater than 16.
REQ-002 Parameter ON_CYCLES, 25_000_000, number of clock cycles each colour LED SHALL stay lit; minimum value 1.
REQ-003 Parameter OFF_CYCLES, 12_500_000, number of clock cycles of dark gap after each colour; minimum value 1.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to play back entries 0..level-1.
REQ-007 abort  input  1  stops playback immediately.
REQ-008 level  input  4  number of entries to play.
REQ-009 rd_addr  output  4  read address driven to sequence_rom.
REQ-010 rd_data  input  2  registered read data from sequence_rom.
REQ-011 led  output  4  one-hot colour display; bit n lit for colour code n.
REQ-012 busy  output  1  high while playback is in progress.
REQ-013 done  output  1  one-cycle pulse when playback completes normally.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, LATCH, SHOW, GAP and FIN.
REQ-015 IDLE: start=1 with abort=0 SHALL load idx=0 and the effective level, then go to FETCH, or go directly to FIN when the effective level is 0.
REQ-016 Effective level SHALL be min(level, DEPTH), sampled once at start; later changes to level SHALL have no effect until the next start.
REQ-017 FETCH: the block SHALL drive rd_addr=idx for one cycle, then go to LATCH.
REQ-018 LATCH: the block SHALL hold rd_addr=idx; at the end of LATCH it SHALL capture rd_data into a colour register, giving a two-edge ROM read latency, then go to SHOW.
REQ-019 SHOW: led SHALL equal 1<<colour for exactly ON_CYCLES cycles, then the FSM SHALL go to GAP.
REQ-020 GAP: led SHALL be 4'b0000 for exactly OFF_CYCLES cycles; then idx SHALL increment and the FSM SHALL return to FETCH if idx+1 < effective level, else go to FIN.
REQ-021 FIN: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-022 busy SHALL be 1 in the states FETCH, LATCH, SHOW and GAP, and 0 in IDLE and FIN.
REQ-023 Each entry SHALL take exactly 2+ON_CYCLES+OFF_CYCLES cycles; with start sampled at edge E0, entry k SHALL light at edge E0+2+k*(2+ON_CYCLES+OFF_CYCLES).
REQ-024 start while busy=1 or in FIN SHALL be ignored.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with led=0 and busy=0, and SHALL produce no done pulse.
REQ-026 abort SHALL take priority over start when both are high in the same cycle.
REQ-027 rd_addr SHALL hold its last value when not in FETCH or LATCH and SHALL never exceed DEPTH-1.
REQ-028 The ON and OFF counters SHALL be sized to $clog2(max(ON_CYCLES,OFF_CYCLES)+1) bits and SHALL clear on every state entry.
REQ-029 led SHALL be one-hot or zero at all times and SHALL never have more than one bit set.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, idx=0, colour=0, rd_addr=0, led=0, busy=0 and done=0, taking priority over start and abort.
REQ-031 Reset during playback SHALL abandon playback with no done pulse, and the block SHALL accept start on the first edge after rst is deasserted.

Verification (DEPTH=4, ON_CYCLES=3, OFF_CYCLES=2, ROM preloaded 0,1,2,3)
REQ-032 With level=4 and start at E0: led SHALL be 0001, 0010, 0100, 1000, each lit 3 cycles starting at E0+2, E0+9, E0+16 and E0+23; done SHALL be high only in the cycle after E0+28.
REQ-033 With level=0 and start: done SHALL pulse in the cycle after start, and busy and led SHALL stay 0 throughout.
REQ-034 With level=9: exactly 4 entries SHALL play, and rd_addr SHALL never exceed 3.
REQ-035 abort asserted while entry 1 is in SHOW: the block SHALL reach IDLE with led=0 and busy=0 at the next edge, with no done pulse; a following start SHALL replay from entry 0.
REQ-036 start pulsed again mid-playback, and start and abort pulsed in the same IDLE cycle: there SHALL be no restart and the block SHALL remain IDLE, respectively.
REQ-037 rst asserted for 1 cycle during GAP: all outputs SHALL be 0 at the next edge, and a start one cycle later SHALL play normally.
